// File: rtl/mac_pipe_acc.sv
// Streaming multiply-accumulate: a registered W x W product stage feeding an
// ACC_W accumulator with optional saturation, valid/ready on both sides.
module mac_pipe_acc #(
    parameter int W     = 8,
    parameter int ACC_W = 20,
    parameter int SAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_cnt
);

    logic               s1_valid_q, s1_valid_d;
    logic [2*W-1:0]     prod_q, prod_d;
    logic               s1_first_q, s1_first_d;
    logic               s1_last_q, s1_last_d;
    logic               s1_signed_q, s1_signed_d;
    logic               mode_q, mode_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic               out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

    logic               stall;
    logic               accept;
    logic               beat_signed;
    logic [2*W-1:0]     prod_u;
    logic [2*W-1:0]     prod_s;
    logic [ACC_W-1:0]   ext;
    logic [ACC_W-1:0]   base;
    logic [ACC_W:0]     sum;
    logic               overflow;
    logic [ACC_W-1:0]   acc_new;
    logic               ovf_new;
    logic [CNT_W-1:0]   cnt_new;

    assign stall       = out_valid_q & ~out_ready;
    assign in_ready    = rst_n & ~stall;
    assign accept      = in_valid & in_ready;
    assign beat_signed = in_first ? in_signed : mode_q;

    // A 2W-bit product of sign-extended operands is the exact signed product.
    assign prod_u = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
    assign prod_s = {{W{in_a[W-1]}}, in_a} * {{W{in_b[W-1]}}, in_b};

    always_comb begin
        ext = '0;
        ext[2*W-1:0] = prod_q;
        if (s1_signed_q) begin
            for (int i = 2*W; i < ACC_W; i++) begin
                ext[i] = prod_q[2*W-1];
            end
        end
        base = s1_first_q ? '0 : acc_q;
        if (s1_signed_q) begin
            sum      = {base[ACC_W-1], base} + {ext[ACC_W-1], ext};
            overflow = sum[ACC_W] ^ sum[ACC_W-1];
        end else begin
            sum      = {1'b0, base} + {1'b0, ext};
            overflow = sum[ACC_W];
        end
        acc_new = sum[ACC_W-1:0];
        // In signed mode the extra sum bit carries the true sign, so it picks min vs max.
        if (overflow && (SAT != 0)) begin
            if (!s1_signed_q) begin
                acc_new = '1;
            end else if (sum[ACC_W]) begin
                acc_new = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                acc_new = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
        ovf_new = (s1_first_q ? 1'b0 : ovf_q) | overflow;
        if (s1_first_q) begin
            cnt_new = CNT_W'(1);
        end else if (&cnt_q) begin
            cnt_new = cnt_q;
        end else begin
            cnt_new = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: every next-state signal defaults to its held value before any branch,
    // so no path through this block can leave a signal unassigned and infer a latch.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        prod_d      = prod_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s1_signed_d = s1_signed_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_ovf_d   = out_ovf_q;
        out_cnt_d   = out_cnt_q;
        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                prod_d      = beat_signed ? prod_s : prod_u;
                s1_first_d  = in_first;
                s1_last_d   = in_last;
                s1_signed_d = beat_signed;
                if (in_first) begin
                    mode_d = in_signed;
                end
            end
            // Not stalled means any held result is consumed on this edge.
            out_valid_d = s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                acc_d = acc_new;
                ovf_d = ovf_new;
                cnt_d = cnt_new;
                if (s1_last_q) begin
                    out_acc_d = acc_new;
                    out_ovf_d = ovf_new;
                    out_cnt_d = cnt_new;
                end
            end
        end
    end

    // NOTE: the reset clears the whole pipeline, datapath included, so a partial
    // accumulation interrupted by reset can never leak into a later result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            prod_q      <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_signed_q <= 1'b0;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register see the
            // pre-edge values of the others, independent of statement order.
            s1_valid_q  <= s1_valid_d;
            prod_q      <= prod_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_signed_q <= s1_signed_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_ovf_q   <= out_ovf_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_mac_pipe_acc.sv
// Self-checking bench for mac_pipe_acc: directed scenarios plus a randomized
// phase scored against an arithmetic reference model of the accumulation.
module tb_mac_pipe_acc;

    localparam int W     = 8;
    localparam int ACC_W = 20;
    localparam int SAT   = 1;
    localparam int CNT_W = 8;
    localparam longint ACC_MOD = longint'(1) << ACC_W;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_first;
    logic             in_last;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic [CNT_W-1:0] out_cnt;

    logic rand_ready = 1'b0;
    logic force_ready = 1'b1;
    logic rnd_ready = 1'b1;
    assign out_ready = rand_ready ? rnd_ready : force_ready;

    mac_pipe_acc #(.W(W), .ACC_W(ACC_W), .SAT(SAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .out_cnt   (out_cnt)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: accumulation over mathematical integers, then clipped or wrapped.
    typedef struct {
        longint acc;
        bit     ovf;
        longint cnt;
    } res_t;

    res_t   exp_q[$];
    longint m_acc  = 0;
    bit     m_mode = 1'b0;
    bit     m_ovf  = 1'b0;
    longint m_cnt  = 0;

    function automatic longint as_signed(input longint v, input int bits);
        return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
    endfunction

    task automatic model_beat(input longint a, input longint b, input bit f, input bit l, input bit s);
        bit     sgn;
        bit     o;
        longint t;
        longint hi;
        longint lo;
        sgn = f ? s : m_mode;
        if (f) m_mode = s;
        if (sgn) begin
            t  = (f ? 0 : as_signed(m_acc, ACC_W)) + as_signed(a, W) * as_signed(b, W);
            hi = ACC_MOD / 2 - 1;
            lo = -(ACC_MOD / 2);
        end else begin
            t  = (f ? 0 : m_acc) + a * b;
            hi = ACC_MOD - 1;
            lo = 0;
        end
        o = (t > hi) || (t < lo);
        if (o && SAT != 0) t = (t > hi) ? hi : lo;
        m_acc = ((t % ACC_MOD) + ACC_MOD) % ACC_MOD;
        m_ovf = (f ? 1'b0 : m_ovf) | o;
        m_cnt = f ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
        if (l) exp_q.push_back('{m_acc, m_ovf, m_cnt});
    endtask

    // Monitor: sampled on the falling edge, describing what the next rising edge does.
    initial begin
        res_t   e;
        bit     hold;
        longint h_acc;
        longint h_cnt;
        bit     h_ovf;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("ready_low_in_reset", in_ready, 0);
                m_acc  = 0;
                m_mode = 1'b0;
                m_ovf  = 1'b0;
                m_cnt  = 0;
                exp_q.delete();
                hold = 1'b0;
            end else begin
                check("ready_rule", in_ready, !(out_valid && !out_ready));
                if (hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_acc", out_acc, h_acc);
                    check("hold_ovf", out_ovf, h_ovf);
                    check("hold_cnt", out_cnt, h_cnt);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out_valid", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_acc", out_acc, e.acc);
                        check("sb_ovf", out_ovf, e.ovf);
                        check("sb_cnt", out_cnt, e.cnt);
                    end
                end
                hold  = out_valid && !out_ready;
                h_acc = out_acc;
                h_ovf = out_ovf;
                h_cnt = out_cnt;
                if (in_valid && in_ready) model_beat(in_a, in_b, in_first, in_last, in_signed);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; returns just after the edge that accepts the beat.
    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic f, input logic l, input logic s);
        int guard = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_first  = f;
        in_last   = l;
        in_signed = s;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("beat_accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output longint acc, output bit ovf, output longint cnt);
        int guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) check("result_timeout", out_valid, 1);
        acc = out_acc;
        ovf = out_ovf;
        cnt = out_cnt;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_op();
        int unsigned r;
        r = $urandom_range(0, 3);
        if (r == 0) return {1'b1, {(W-1){1'b0}}};
        if (r == 1) return '1;
        return W'($urandom);
    endfunction

    initial begin
        longint r_acc;
        longint r_cnt;
        bit     r_ovf;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_first = 1'b0;
        in_last = 1'b0;
        in_signed = 1'b0;
        force_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_acc", out_acc, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_cnt", out_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Non-first beat straight after reset: unsigned mode, accumulates onto zero.
        beat(8'hFF, 8'h02, 1'b0, 1'b1, 1'b1);
        wait_result(r_acc, r_ovf, r_cnt);
        check("t0_acc", r_acc, 510);
        check("t0_cnt", r_cnt, 1);

        // Single unsigned beat and its latency.
        beat(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t1_not_yet_valid", out_valid, 0);
        @(negedge clk);
        check("t1_valid", out_valid, 1);
        check("t1_acc", out_acc, 65025);
        check("t1_ovf", out_ovf, 0);
        check("t1_cnt", out_cnt, 1);
        @(posedge clk);
        #1;

        // Signed stream; in_signed on later beats must be ignored.
        beat(8'h80, 8'h7F, 1'b1, 1'b0, 1'b1);
        beat(8'hFD, 8'h05, 1'b0, 1'b0, 1'b0);
        beat(8'd100, 8'd100, 1'b0, 1'b0, 1'b0);
        beat(8'h07, 8'hF7, 1'b0, 1'b1, 1'b0);
        wait_result(r_acc, r_ovf, r_cnt);
        check("t2_acc", r_acc, 'hFE742);
        check("t2_ovf", r_ovf, 0);
        check("t2_cnt", r_cnt, 4);

        // Unsigned overflow over 17 beats.
        for (int i = 0; i < 17; i++) begin
            beat(8'hFF, 8'hFF, logic'(i == 0), logic'(i == 16), 1'b0);
        end
        wait_result(r_acc, r_ovf, r_cnt);
        check("t3_acc", r_acc, (SAT != 0) ? 'hFFFFF : 56849);
        check("t3_ovf", r_ovf, 1);
        check("t3_cnt", r_cnt, 17);

        // Backpressure: result A held while result B waits in the pipeline.
        force_ready = 1'b0;
        beat(8'd2, 8'd3, 1'b1, 1'b0, 1'b0);
        beat(8'd4, 8'd5, 1'b0, 1'b1, 1'b0);
        beat(8'd6, 8'd7, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_acc", out_acc, 26);
            check("t4_hold_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        force_ready = 1'b1;
        @(negedge clk);
        check("t4_release_acc", out_acc, 26);
        @(negedge clk);
        check("t4_b_valid", out_valid, 1);
        check("t4_b_acc", out_acc, 42);
        check("t4_b_ovf", out_ovf, 0);
        check("t4_b_cnt", out_cnt, 1);
        @(negedge clk);
        check("t4_no_duplicate", out_valid, 0);
        @(posedge clk);
        #1;

        // Reset mid-stream discards the partial accumulation.
        beat(8'd10, 8'd10, 1'b1, 1'b0, 1'b0);
        beat(8'd10, 8'd10, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_ready_in_reset", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(8'd3, 8'd4, 1'b1, 1'b1, 1'b0);
        wait_result(r_acc, r_ovf, r_cnt);
        check("t5_acc", r_acc, 12);
        check("t5_cnt", r_cnt, 1);

        // Back-to-back single-beat streams.
        beat(8'd9, 8'd9, 1'b1, 1'b1, 1'b0);
        beat(8'd8, 8'd8, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("t6_first_valid", out_valid, 1);
        check("t6_first_acc", out_acc, 81);
        @(negedge clk);
        check("t6_second_valid", out_valid, 1);
        check("t6_second_acc", out_acc, 64);
        @(posedge clk);
        #1;

        // A non-first beat after a completed result continues the same accumulation.
        beat(8'd1, 8'd1, 1'b0, 1'b1, 1'b1);
        wait_result(r_acc, r_ovf, r_cnt);
        check("t6b_acc", r_acc, 65);
        check("t6b_cnt", r_cnt, 2);

        // Beat counter saturation.
        for (int i = 0; i < 300; i++) begin
            beat(8'd0, 8'd0, logic'(i == 0), logic'(i == 299), 1'b0);
        end
        wait_result(r_acc, r_ovf, r_cnt);
        check("t7_cnt_sat", r_cnt, CNT_MAX);
        check("t7_acc", r_acc, 0);

        // Randomized traffic with random backpressure, scored by the monitor.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            beat(rand_op(), rand_op(), logic'($urandom_range(0, 7) == 0),
                 logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 1)));
        end
        force_ready = 1'b1;
        rand_ready  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
